// File: rtl/fcart_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fcart_mem_pkg
//  Description : Shared types for the cartridge memory arbiter: requester
//                identifiers and the arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fcart_mem_pkg;

    // Requester identifiers, in fixed-priority order (PPU highest).
    typedef enum logic [1:0] {
        REQ_PPU = 2'd0,
        REQ_CPU = 2'd1,
        REQ_MCU = 2'd2
    } req_id_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Read data returned to a requester whose transaction was aborted.
    localparam logic [7:0] c_TIMEOUT_RDATA = 8'hFF;

endpackage : fcart_mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Three-port (PPU/CPU/MCU) arbiter onto a single 8-bit memory
//                port. Fixed priority PPU > CPU > MCU with an MCU starvation
//                override and a BUSY watchdog that aborts stuck transactions.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                {ppu,cpu,mcu}_req/addr     - level requests and addresses
//                {cpu,mcu}_we/wdata         - write select and write data
//                {ppu,cpu,mcu}_ack/rdata    - completion pulse, held read data
//                mem_req/we/addr/wdata      - memory request side
//                mem_ack/rdata              - memory completion, same-cycle data
//                timeout                    - one-cycle abort indication
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import fcart_mem_pkg::*;
#(
    parameter int ADDR_BITS    = 22,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ppu_req,
    input  logic                 cpu_req,
    input  logic                 mcu_req,
    input  logic [ADDR_BITS-1:0] ppu_addr,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [ADDR_BITS-1:0] mcu_addr,
    input  logic                 cpu_we,
    input  logic                 mcu_we,
    input  logic [7:0]           cpu_wdata,
    input  logic [7:0]           mcu_wdata,
    output logic                 ppu_ack,
    output logic                 cpu_ack,
    output logic                 mcu_ack,
    output logic [7:0]           ppu_rdata,
    output logic [7:0]           cpu_rdata,
    output logic [7:0]           mcu_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_rdata,
    output logic                 timeout
);

    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_LIMIT);
    localparam logic [c_WD_W-1:0]  c_WD_LAST    = c_WD_W'(TIMEOUT - 1);

    arb_state_t           r_state;
    req_id_t              r_gnt;
    logic                 r_gnt_we;
    logic                 r_armed;
    logic [c_STV_W-1:0]   r_starve;
    logic [c_WD_W-1:0]    r_wdog;
    logic [7:0]           r_cap;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [7:0]           r_mem_wdata;
    logic                 r_ppu_ack;
    logic                 r_cpu_ack;
    logic                 r_mcu_ack;
    logic [7:0]           r_ppu_rdata;
    logic [7:0]           r_cpu_rdata;
    logic [7:0]           r_mcu_rdata;
    logic                 r_timeout;

    req_id_t              w_gnt;
    logic                 w_any;
    logic                 w_grant_now;
    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_we;
    logic [7:0]           w_wdata;

    // Grant select. The starvation override is checked first so a saturated
    // counter beats any higher-priority request present in the same cycle.
    always_comb begin
        w_any = ppu_req | cpu_req | mcu_req;
        w_gnt = REQ_MCU;
        if (mcu_req && (r_starve == c_STARVE_MAX)) begin
            w_gnt = REQ_MCU;
        end else if (ppu_req) begin
            w_gnt = REQ_PPU;
        end else if (cpu_req) begin
            w_gnt = REQ_CPU;
        end
    end

    // r_armed blocks the first edge after reset release, so the earliest
    // grant lands on the second edge.
    assign w_grant_now = (r_state == ST_IDLE) && r_armed && w_any;

    always_comb begin
        w_addr  = mcu_addr;
        w_we    = mcu_we;
        w_wdata = mcu_wdata;
        case (w_gnt)
            REQ_PPU: begin
                w_addr  = ppu_addr;
                w_we    = 1'b0;
                w_wdata = 8'h00;
            end
            REQ_CPU: begin
                w_addr  = cpu_addr;
                w_we    = cpu_we;
                w_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= REQ_PPU;
            r_gnt_we    <= 1'b0;
            r_armed     <= 1'b0;
            r_starve    <= '0;
            r_wdog      <= '0;
            r_cap       <= 8'h00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_ppu_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_mcu_ack   <= 1'b0;
            r_ppu_rdata <= 8'h00;
            r_cpu_rdata <= 8'h00;
            r_mcu_rdata <= 8'h00;
            r_timeout   <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_ppu_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_mcu_ack <= 1'b0;
            r_timeout <= 1'b0;

            // Saturating count of grants that bypassed a waiting MCU.
            if (!mcu_req) begin
                r_starve <= '0;
            end else if (w_grant_now) begin
                if (w_gnt == REQ_MCU) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_now) begin
                        r_gnt       <= w_gnt;
                        r_gnt_we    <= w_we;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_we;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_wdog      <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cap     <= mem_rdata;
                        r_state   <= ST_DONE;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cap     <= c_TIMEOUT_RDATA;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    case (r_gnt)
                        REQ_PPU: begin
                            r_ppu_ack   <= 1'b1;
                            r_ppu_rdata <= r_cap;
                        end
                        REQ_CPU: begin
                            r_cpu_ack <= 1'b1;
                            if (!r_gnt_we) r_cpu_rdata <= r_cap;
                        end
                        default: begin
                            r_mcu_ack <= 1'b1;
                            if (!r_gnt_we) r_mcu_rdata <= r_cap;
                        end
                    endcase
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ppu_ack   = r_ppu_ack;
    assign cpu_ack   = r_cpu_ack;
    assign mcu_ack   = r_mcu_ack;
    assign ppu_rdata = r_ppu_rdata;
    assign cpu_rdata = r_cpu_rdata;
    assign mcu_rdata = r_mcu_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign timeout   = r_timeout;

endmodule : mem_arbiter
`default_nettype wire
